// File: rtl/multicycle_datapath_core.sv
// -----------------------------------------------------------------------------
// multicycle_datapath_core
//
// Datapath of a multicycle RV32I-subset processor. It holds the architectural
// PC and the inter-cycle registers (PCBack, IR, MDR, A, B, ALUOut). It also
// contains the immediate generator, the ALU control decoder and the ALU. The
// external control FSM drives the strobes every cycle and receives the
// instruction word back on oInstr.
//
// Ports:
//   iCLK, iRST          clock (rising edge), asynchronous active-high reset
//   iEscrevePC          unconditional PC write
//   iEscrevePCCond      PC write qualified by the ALU zero flag
//   iIouD               memory address select (0 = PC, 1 = ALUOut)
//   iEscreveIR          IR load enable
//   iMem2Reg[1:0]       writeback select (ALUOut / PC / MDR / 0)
//   iOrigPC             PC source (0 = ALU result, 1 = ALUOut)
//   iOrigAULA[1:0]      ALU A source (PCBack / A / PC / 0)
//   iOrigBULA[1:0]      ALU B source (B / 4 / Imm / 0)
//   iALUOp[1:0]         add / sub / decode funct / add
//   iEscreveReg         register-file write request (passed through)
//   iEscrevePCB         PCBack load enable
//   iMemData            memory read data
//   iRs1Data, iRs2Data  register-file read data
//   oMemAddr, oMemWData memory address and write data
//   oInstr              IR contents to the control FSM
//   oRs1, oRs2, oRd     register specifiers decoded from IR
//   oRegWrite, oRegWData register-file write strobe and data
//   oPC                 current PC
//   oZero               ALU result equals zero
// -----------------------------------------------------------------------------
module multicycle_datapath_core #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   PC_RESET = 32'h0040_0000
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iEscrevePC,
  input  logic            iEscrevePCCond,
  input  logic            iIouD,
  input  logic            iEscreveIR,
  input  logic [1:0]      iMem2Reg,
  input  logic            iOrigPC,
  input  logic [1:0]      iOrigAULA,
  input  logic [1:0]      iOrigBULA,
  input  logic [1:0]      iALUOp,
  input  logic            iEscreveReg,
  input  logic            iEscrevePCB,
  input  logic [XLEN-1:0] iMemData,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  output logic [XLEN-1:0] oMemAddr,
  output logic [XLEN-1:0] oMemWData,
  output logic [XLEN-1:0] oInstr,
  output logic [4:0]      oRs1,
  output logic [4:0]      oRs2,
  output logic [4:0]      oRd,
  output logic            oRegWrite,
  output logic [XLEN-1:0] oRegWData,
  output logic [XLEN-1:0] oPC,
  output logic            oZero
);

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] FOUR_WORD = 32'h0000_0004;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_e;

  // Architectural and inter-cycle registers
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcback_q;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] mdr_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] aluout_q;

  // Combinational datapath signals
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] alu_a_s;
  logic [XLEN-1:0] alu_b_s;
  logic [XLEN-1:0] alu_res_s;
  logic [XLEN-1:0] regwdata_s;
  logic            zero_s;
  logic            pc_we_s;
  alu_ctrl_e       alu_ctrl_s;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       funct7b5_s;

  assign opcode_s   = ir_q[6:0];
  assign funct3_s   = ir_q[14:12];
  assign funct7b5_s = ir_q[30];

  // Immediate generator: format chosen by opcode, always sign-extended from IR[31]
  always_comb begin
    imm_s = ZERO_WORD;
    case (opcode_s)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm_s = {{20{ir_q[31]}}, ir_q[31:20]};
      OPC_STORE:
        imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OPC_BRANCH:
        imm_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OPC_JAL:
        imm_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:
        imm_s = ZERO_WORD;
    endcase
  end

  // ALU control: funct7[5] selects sub only for register-register ops, so ADDI never subtracts
  always_comb begin
    alu_ctrl_s = ALU_ADD;
    case (iALUOp)
      2'b00: alu_ctrl_s = ALU_ADD;
      2'b01: alu_ctrl_s = ALU_SUB;
      2'b10: begin
        case (funct3_s)
          3'b000: begin
            if (funct7b5_s && (opcode_s == OPC_OP)) begin
              alu_ctrl_s = ALU_SUB;
            end else begin
              alu_ctrl_s = ALU_ADD;
            end
          end
          3'b111:  alu_ctrl_s = ALU_AND;
          3'b110:  alu_ctrl_s = ALU_OR;
          3'b010:  alu_ctrl_s = ALU_SLT;
          default: alu_ctrl_s = ALU_ADD;
        endcase
      end
      2'b11:   alu_ctrl_s = ALU_ADD;
      default: alu_ctrl_s = ALU_ADD;
    endcase
  end

  // ALU operand A select
  always_comb begin
    alu_a_s = ZERO_WORD;
    case (iOrigAULA)
      2'b00:   alu_a_s = pcback_q;
      2'b01:   alu_a_s = a_q;
      2'b10:   alu_a_s = pc_q;
      2'b11:   alu_a_s = ZERO_WORD;
      default: alu_a_s = ZERO_WORD;
    endcase
  end

  // ALU operand B select
  always_comb begin
    alu_b_s = ZERO_WORD;
    case (iOrigBULA)
      2'b00:   alu_b_s = b_q;
      2'b01:   alu_b_s = FOUR_WORD;
      2'b10:   alu_b_s = imm_s;
      2'b11:   alu_b_s = ZERO_WORD;
      default: alu_b_s = ZERO_WORD;
    endcase
  end

  // ALU: 32-bit wraparound arithmetic, signed set-less-than yields 0/1
  always_comb begin
    alu_res_s = ZERO_WORD;
    case (alu_ctrl_s)
      ALU_ADD: alu_res_s = alu_a_s + alu_b_s;
      ALU_SUB: alu_res_s = alu_a_s - alu_b_s;
      ALU_AND: alu_res_s = alu_a_s & alu_b_s;
      ALU_OR:  alu_res_s = alu_a_s | alu_b_s;
      ALU_SLT: begin
        if ($signed(alu_a_s) < $signed(alu_b_s)) begin
          alu_res_s = {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
          alu_res_s = ZERO_WORD;
        end
      end
      default: alu_res_s = ZERO_WORD;
    endcase
  end

  assign zero_s  = (alu_res_s == ZERO_WORD);
  assign pc_we_s = iEscrevePC | (iEscrevePCCond & zero_s);

  // Next PC: branch target comes from ALUOut (computed in decode), other jumps from the ALU
  always_comb begin
    pc_d = pc_q;
    if (pc_we_s) begin
      if (iOrigPC) begin
        pc_d = aluout_q;
      end else begin
        pc_d = alu_res_s;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Writeback select; PC here is the pre-edge value, which is the JAL/JALR link address
  always_comb begin
    regwdata_s = ZERO_WORD;
    case (iMem2Reg)
      2'b00:   regwdata_s = aluout_q;
      2'b01:   regwdata_s = pc_q;
      2'b10:   regwdata_s = mdr_q;
      2'b11:   regwdata_s = ZERO_WORD;
      default: regwdata_s = ZERO_WORD;
    endcase
  end

  // Datapath registers; PCBack samples the PC before this edge's update
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pc_q     <= PC_RESET;
      pcback_q <= PC_RESET;
      ir_q     <= NOP_INSTR;
      mdr_q    <= ZERO_WORD;
      a_q      <= ZERO_WORD;
      b_q      <= ZERO_WORD;
      aluout_q <= ZERO_WORD;
    end else begin
      pc_q     <= pc_d;
      if (iEscrevePCB) begin
        pcback_q <= pc_q;
      end
      if (iEscreveIR) begin
        ir_q <= iMemData;
      end
      mdr_q    <= iMemData;
      a_q      <= iRs1Data;
      b_q      <= iRs2Data;
      aluout_q <= alu_res_s;
    end
  end

  assign oMemAddr  = iIouD ? aluout_q : pc_q;
  assign oMemWData = b_q;
  assign oInstr    = ir_q;
  assign oRs1      = ir_q[19:15];
  assign oRs2      = ir_q[24:20];
  assign oRd       = ir_q[11:7];
  assign oRegWrite = iEscreveReg;
  assign oRegWData = regwdata_s;
  assign oPC       = pc_q;
  assign oZero     = zero_s;

endmodule

// File: tb/tb_multicycle_datapath_core.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath_core
//
// Directed bench for the multicycle datapath. It plays the role of the control
// FSM by driving strobe sequences for fetch, ADDI, R-type ALU ops, BEQ,
// load/store and JAL. Expected values are hand-computed from the instruction
// encodings.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath_core;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iEscrevePC, iEscrevePCCond, iIouD, iEscreveIR, iOrigPC;
  logic [1:0]  iMem2Reg, iOrigAULA, iOrigBULA, iALUOp;
  logic        iEscreveReg, iEscrevePCB;
  logic [31:0] iMemData, iRs1Data, iRs2Data;
  logic [31:0] oMemAddr, oMemWData, oInstr, oRegWData, oPC;
  logic [4:0]  oRs1, oRs2, oRd;
  logic        oRegWrite, oZero;

  int checks = 0;
  int errors = 0;

  multicycle_datapath_core #(.XLEN(32), .PC_RESET(PC_RST)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iEscrevePC(iEscrevePC), .iEscrevePCCond(iEscrevePCCond), .iIouD(iIouD),
    .iEscreveIR(iEscreveIR), .iMem2Reg(iMem2Reg), .iOrigPC(iOrigPC),
    .iOrigAULA(iOrigAULA), .iOrigBULA(iOrigBULA), .iALUOp(iALUOp),
    .iEscreveReg(iEscreveReg), .iEscrevePCB(iEscrevePCB),
    .iMemData(iMemData), .iRs1Data(iRs1Data), .iRs2Data(iRs2Data),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oInstr(oInstr),
    .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd), .oRegWrite(oRegWrite),
    .oRegWData(oRegWData), .oPC(oPC), .oZero(oZero)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    iEscrevePC = 1'b0; iEscrevePCCond = 1'b0; iIouD = 1'b0; iEscreveIR = 1'b0;
    iOrigPC = 1'b0; iMem2Reg = 2'b00; iOrigAULA = 2'b00; iOrigBULA = 2'b00;
    iALUOp = 2'b00; iEscreveReg = 1'b0; iEscrevePCB = 1'b0;
  endtask

  // Fetch cycle: IR <= mem[PC], PCBack <= PC, PC <= PC + 4
  task automatic fetch(input logic [31:0] instr);
    iMemData = instr;
    iEscrevePC = 1'b1; iEscreveIR = 1'b1; iEscrevePCB = 1'b1;
    iOrigAULA = 2'b10; iOrigBULA = 2'b01; iALUOp = 2'b00; iOrigPC = 1'b0; iIouD = 1'b0;
    tick();
    idle();
  endtask

  // Load IR only (PC untouched); A and B pick up the register data on the same edge
  task automatic load_ir(input logic [31:0] instr);
    iMemData = instr;
    iEscreveIR = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (oPC !== PC_RST) begin errors++; $display("FAIL reset_pc got %h exp %h", oPC, PC_RST); end
    checks++; if (oInstr !== 32'h0000_0013) begin errors++; $display("FAIL reset_ir got %h exp %h", oInstr, 32'h0000_0013); end
    checks++; if (oMemAddr !== PC_RST) begin errors++; $display("FAIL reset_addr got %h exp %h", oMemAddr, PC_RST); end
    checks++; if (oMemWData !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", oMemWData); end
    checks++; if (oRegWData !== 32'h0) begin errors++; $display("FAIL reset_aluout got %h exp 0", oRegWData); end
    @(negedge iCLK);
    iRST = 1'b0;
    tick();
    checks++; if (oPC !== PC_RST) begin errors++; $display("FAIL idle_pc_hold got %h exp %h", oPC, PC_RST); end
  endtask

  task automatic test_fetch();
    iMemData = 32'h0050_0093;
    iEscrevePC = 1'b1; iEscreveIR = 1'b1; iEscrevePCB = 1'b1;
    iOrigAULA = 2'b10; iOrigBULA = 2'b01; iALUOp = 2'b00;
    #1;
    checks++; if (oMemAddr !== PC_RST) begin errors++; $display("FAIL fetch_addr got %h exp %h", oMemAddr, PC_RST); end
    tick();
    idle();
    iMemData = 32'hDEAD_BEEF;
    checks++; if (oInstr !== 32'h0050_0093) begin errors++; $display("FAIL fetch_ir got %h exp %h", oInstr, 32'h0050_0093); end
    checks++; if (oPC !== 32'h0040_0004) begin errors++; $display("FAIL fetch_pc got %h exp %h", oPC, 32'h0040_0004); end
    checks++; if (oRd !== 5'd1) begin errors++; $display("FAIL fetch_rd got %0d exp 1", oRd); end
    // Expose PCBack via ALUOut: PCBack + 0
    iOrigAULA = 2'b00; iOrigBULA = 2'b11; iALUOp = 2'b00;
    tick();
    idle();
    iIouD = 1'b1;
    #1;
    checks++; if (oMemAddr !== 32'h0040_0000) begin errors++; $display("FAIL fetch_pcback got %h exp %h", oMemAddr, 32'h0040_0000); end
    checks++; if (oInstr !== 32'h0050_0093) begin errors++; $display("FAIL ir_hold got %h exp %h", oInstr, 32'h0050_0093); end
    idle();
  endtask

  task automatic test_addi();
    iRs1Data = 32'h0;
    tick();
    iOrigAULA = 2'b01; iOrigBULA = 2'b10; iALUOp = 2'b10;
    #1;
    checks++; if (oZero !== 1'b0) begin errors++; $display("FAIL addi_zero got %b exp 0", oZero); end
    tick();
    idle();
    iMem2Reg = 2'b00; iEscreveReg = 1'b1;
    #1;
    checks++; if (oRegWData !== 32'd5) begin errors++; $display("FAIL addi_wb got %h exp 5", oRegWData); end
    checks++; if (oRegWrite !== 1'b1) begin errors++; $display("FAIL addi_regwrite got %b exp 1", oRegWrite); end
    idle();
    #1;
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL regwrite_low got %b exp 0", oRegWrite); end
  endtask

  // Execute one ALU op: A/B from register data, result observed through ALUOut
  task automatic r_op(input string nm, input logic [31:0] instr, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] srcb, input logic [1:0] aluop,
                      input logic [31:0] exp);
    iRs1Data = a; iRs2Data = b;
    load_ir(instr);
    iOrigAULA = 2'b01; iOrigBULA = srcb; iALUOp = aluop;
    #1;
    checks++; if (oZero !== (exp == 32'h0)) begin errors++; $display("FAIL %s_zero got %b exp %b", nm, oZero, (exp == 32'h0)); end
    tick();
    idle();
    iIouD = 1'b1;
    #1;
    checks++; if (oMemAddr !== exp) begin errors++; $display("FAIL %s got %h exp %h", nm, oMemAddr, exp); end
    idle();
  endtask

  task automatic test_alu();
    r_op("add",      32'h0020_81B3, 32'd7,         32'd8,        2'b00, 2'b10, 32'd15);
    r_op("sub",      32'h4020_81B3, 32'd7,         32'd8,        2'b00, 2'b10, 32'hFFFF_FFFF);
    r_op("sub_zero", 32'h4020_81B3, 32'h1234_5678, 32'h1234_5678, 2'b00, 2'b10, 32'h0);
    r_op("and",      32'h0020_F1B3, 32'h0000_F0F0, 32'h0000_FF00, 2'b00, 2'b10, 32'h0000_F000);
    r_op("or",       32'h0020_E1B3, 32'h0000_F0F0, 32'h0000_FF00, 2'b00, 2'b10, 32'h0000_FFF0);
    r_op("slt_neg",  32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1,        2'b00, 2'b10, 32'd1);
    r_op("slt_gt",   32'h0020_A1B3, 32'd5,         32'd3,        2'b00, 2'b10, 32'd0);
    r_op("f3_other", 32'h0020_91B3, 32'd7,         32'd8,        2'b00, 2'b10, 32'd15);
    r_op("add_wrap", 32'h0020_81B3, 32'h7FFF_FFFF, 32'd1,        2'b00, 2'b10, 32'h8000_0000);
    r_op("addi_neg", 32'hFFF0_0093, 32'd0,         32'd0,        2'b10, 2'b10, 32'hFFFF_FFFF);
    r_op("addi_b30", 32'h4000_0093, 32'd3,         32'd0,        2'b10, 2'b10, 32'h0000_0403);
    r_op("ori",      32'h0FF0_E093, 32'h0000_0F00, 32'd0,        2'b10, 2'b10, 32'h0000_0FFF);
    r_op("op01_sub", 32'h0020_81B3, 32'd10,        32'd3,        2'b00, 2'b01, 32'd7);
    r_op("op11_add", 32'h4020_81B3, 32'd10,        32'd3,        2'b00, 2'b11, 32'd13);
    r_op("plus4",    32'h0020_81B3, 32'd10,        32'd3,        2'b01, 2'b00, 32'd14);
  endtask

  task automatic beq_case(input string nm, input logic [31:0] rs2v, input logic exp_zero,
                          input logic [31:0] exp_pc);
    fetch(32'h0020_8463);
    // Decode: ALUOut <= PCBack + Imm
    iRs1Data = 32'd7; iRs2Data = rs2v;
    iOrigAULA = 2'b00; iOrigBULA = 2'b10; iALUOp = 2'b00;
    tick();
    idle();
    // Branch: A - B, PC <= ALUOut if zero
    iOrigAULA = 2'b01; iOrigBULA = 2'b00; iALUOp = 2'b01; iEscrevePCCond = 1'b1; iOrigPC = 1'b1;
    #1;
    checks++; if (oZero !== exp_zero) begin errors++; $display("FAIL %s_zero got %b exp %b", nm, oZero, exp_zero); end
    tick();
    idle();
    checks++; if (oPC !== exp_pc) begin errors++; $display("FAIL %s_pc got %h exp %h", nm, oPC, exp_pc); end
  endtask

  task automatic test_beq();
    beq_case("beq_taken", 32'd7, 1'b1, 32'h0040_000C);
    checks++; if (oRs1 !== 5'd1 || oRs2 !== 5'd2) begin errors++; $display("FAIL beq_rs got %0d/%0d exp 1/2", oRs1, oRs2); end
    beq_case("beq_not",   32'd8, 1'b0, 32'h0040_0010);
  endtask

  task automatic test_lwsw();
    iRs1Data = 32'h1001_0004; iRs2Data = 32'hCAFE_F00D;
    load_ir(32'hFE20_AE23);
    // Effective address: A + (-4)
    iOrigAULA = 2'b01; iOrigBULA = 2'b10; iALUOp = 2'b00;
    tick();
    idle();
    iIouD = 1'b1;
    #1;
    checks++; if (oMemAddr !== 32'h1001_0000) begin errors++; $display("FAIL mem_addr got %h exp %h", oMemAddr, 32'h1001_0000); end
    checks++; if (oMemWData !== 32'hCAFE_F00D) begin errors++; $display("FAIL mem_wdata got %h exp %h", oMemWData, 32'hCAFE_F00D); end
    iMemData = 32'h1234_5678;
    tick();
    idle();
    iMemData = 32'h0;
    iMem2Reg = 2'b10; iEscreveReg = 1'b1;
    #1;
    checks++; if (oRegWData !== 32'h1234_5678) begin errors++; $display("FAIL lw_wb got %h exp %h", oRegWData, 32'h1234_5678); end
    iMem2Reg = 2'b11;
    #1;
    checks++; if (oRegWData !== 32'h0) begin errors++; $display("FAIL wb_zero got %h exp 0", oRegWData); end
    iMem2Reg = 2'b01;
    #1;
    checks++; if (oRegWData !== 32'h0040_0010) begin errors++; $display("FAIL wb_pc got %h exp %h", oRegWData, 32'h0040_0010); end
    idle();
  endtask

  task automatic test_reset_mid();
    iMemData = 32'hFFFF_FFFF;
    iEscrevePC = 1'b1; iEscreveIR = 1'b1; iEscrevePCB = 1'b1;
    iOrigAULA = 2'b10; iOrigBULA = 2'b01;
    @(posedge iCLK);
    #3;
    iRST = 1'b1;
    #1;
    checks++; if (oPC !== PC_RST) begin errors++; $display("FAIL rmid_pc got %h exp %h", oPC, PC_RST); end
    checks++; if (oInstr !== 32'h0000_0013) begin errors++; $display("FAIL rmid_ir got %h exp %h", oInstr, 32'h0000_0013); end
    checks++; if (oMemAddr !== PC_RST) begin errors++; $display("FAIL rmid_addr got %h exp %h", oMemAddr, PC_RST); end
    iIouD = 1'b1;
    #1;
    checks++; if (oMemAddr !== 32'h0) begin errors++; $display("FAIL rmid_aluout got %h exp 0", oMemAddr); end
    checks++; if (oMemWData !== 32'h0) begin errors++; $display("FAIL rmid_b got %h exp 0", oMemWData); end
    tick();
    checks++; if (oPC !== PC_RST) begin errors++; $display("FAIL rmid_hold got %h exp %h", oPC, PC_RST); end
    idle();
    @(negedge iCLK);
    iRST = 1'b0;
  endtask

  task automatic test_jal();
    fetch(32'h0080_00EF);
    checks++; if (oPC !== 32'h0040_0004) begin errors++; $display("FAIL jal_fetch_pc got %h exp %h", oPC, 32'h0040_0004); end
    iOrigAULA = 2'b00; iOrigBULA = 2'b10; iALUOp = 2'b00; iOrigPC = 1'b0;
    iEscrevePC = 1'b1; iEscreveReg = 1'b1; iMem2Reg = 2'b01;
    #1;
    checks++; if (oRegWData !== 32'h0040_0004) begin errors++; $display("FAIL jal_link got %h exp %h", oRegWData, 32'h0040_0004); end
    checks++; if (oRd !== 5'd1) begin errors++; $display("FAIL jal_rd got %0d exp 1", oRd); end
    tick();
    idle();
    checks++; if (oPC !== 32'h0040_0008) begin errors++; $display("FAIL jal_pc got %h exp %h", oPC, 32'h0040_0008); end
  endtask

  initial begin
    iRST = 1'b1;
    idle();
    iMemData = 32'h0; iRs1Data = 32'h0; iRs2Data = 32'h0;
    test_reset();
    test_fetch();
    test_addi();
    test_alu();
    test_beq();
    test_lwsw();
    test_reset_mid();
    test_jal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath_core.md
Name: multicycle_datapath_core

Overview:
- Multicycle RISC-V (RV32I subset) datapath driven by the multicycle control FSM. It consumes the FSM's control strobes every cycle.
- Holds the architectural and inter-cycle registers: PC, PCBack, IR, MDR, A, B, ALUOut. Also contains immediate generation, ALU control and the ALU.
- Feeds the instruction word (oInstr) back to the control FSM.
- Talks to the unified instruction/data memory and to the external register file.

Parameters:
- PC_RESET, 32'h0040_0000, PC value after reset.
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- iCLK  in  1  clock; all registers update on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iEscrevePC  in  1  unconditional PC write.
- iEscrevePCCond  in  1  PC write qualified by ALU zero.
- iIouD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- iEscreveIR  in  1  IR load enable.
- iMem2Reg  in  2  writeback select: 00 = ALUOut, 01 = PC, 10 = MDR, 11 = 0.
- iOrigPC  in  1  PC source: 0 = ALU result, 1 = ALUOut.
- iOrigAULA  in  2  ALU A source: 00 = PCBack, 01 = A, 10 = PC, 11 = 0.
- iOrigBULA  in  2  ALU B source: 00 = B, 01 = 4, 10 = Imm, 11 = 0.
- iALUOp  in  2  00 = add, 01 = sub, 10 = decode funct3/funct7, 11 = add.
- iEscreveReg  in  1  register-file write request.
- iEscrevePCB  in  1  PCBack load enable (PCBack <= PC).
- iMemData  in  32  memory read data.
- iRs1Data, iRs2Data  in  32  register-file read ports.
- oMemAddr  out  32  memory address.
- oMemWData  out  32  memory write data (= B register).
- oInstr  out  32  IR contents, to control FSM.
- oRs1, oRs2, oRd  out  5  IR[19:15], IR[24:20], IR[11:7].
- oRegWrite  out  1  = iEscreveReg.
- oRegWData  out  32  writeback value.
- oPC  out  32  current PC (debug).
- oZero  out  1  ALU result == 0.

Behaviour:
- Reset (async):
  - PC = PC_RESET, PCBack = PC_RESET.
  - IR = 32'h0000_0013 (nop); MDR, A, B, ALUOut = 0.
  - All outputs follow from these register values.
- Every edge, unconditionally:
  - MDR <= iMemData, A <= iRs1Data, B <= iRs2Data, ALUOut <= ALU result.
- IR <= iMemData only when iEscreveIR = 1; otherwise it holds.
- PCBack <= PC when iEscrevePCB = 1. It samples the pre-update PC, so in the fetch cycle PCBack = address of the fetched instruction.
- PC write enable = iEscrevePC | (iEscrevePCCond & oZero). Source is selected by iOrigPC.
- Simultaneous PC write and iEscreveReg with iMem2Reg = 01: oRegWData uses the current, pre-edge PC. This gives the JAL/JALR link value PC+4.
- oMemAddr = iIouD ? ALUOut : PC. Purely combinational.
- Immediate, selected by IR[6:0]:
  - 0010011, 0000011, 1100111: I-type.
  - 0100011: S-type.
  - 1100011: B-type (bit0 = 0).
  - 1101111: J-type (bit0 = 0).
  - All others: 0.
  - All immediates are sign-extended from IR[31].
- ALU control when iALUOp = 10:
  - funct3 000 + funct7[5] = 1 and opcode 0110011: sub; otherwise add. ADDI always adds.
  - 111 and; 110 or; 010 slt (signed, result 0/1).
  - Other funct3: add.
- ALU arithmetic is 32-bit wraparound; overflow is ignored; oZero is combinational from the ALU result.
- Branch sequence: the decode cycle computes PCBack + Imm into ALUOut. The branch cycle computes A - B and, if zero, loads PC from ALUOut.
- Reset mid-instruction: all registers return to reset values immediately; no partial write survives.

Test Plan:
- Reset: assert iRST mid-cycle -> PC = 0x00400000, oInstr = 0x00000013, oMemAddr = 0x00400000 with no clock edge.
- Fetch: iMemData = 0x00500093 (addi x1,x0,5), fetch strobes (EscrevePC, EscreveIR, EscrevePCB, A = PC, B = 4) -> IR = 0x00500093, PC = 0x00400004, PCBack = 0x00400000.
- ADDI execute: A = 0, B = Imm -> ALUOut = 5. Writeback with Mem2Reg = 00 -> oRegWData = 5, oRd = 1, oRegWrite = 1.
- BEQ: IR = 0x00208463 (beq x1,x2,+8), decode then execute:
  - rs1 = rs2 = 7 -> PC = PCBack + 8.
  - rs1 = 7, rs2 = 8 -> PC unchanged.
- JAL: IR = 0x008000EF, PC = 0x00400004 -> oRegWData = 0x00400004 and PC = 0x00400008 on the same edge.
- LW/SW: IouD = 1, ALUOut = 0x10010000 -> oMemAddr = 0x10010000, oMemWData = B; MDR = iMemData the next cycle; Mem2Reg = 10 writes it back.
